vga_sync_gen: RTL and testbench

//  Raster timing generator feeding the pattern/pixel stage of tt_um_devinatkin_vga.

---
 rtl/vga_sync_gen.sv | 125 ++++++++++++
 tb/tb_vga_sync_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel divider, h/v position counters, registered
// sync/blanking outputs, line/frame strobes and a free-running frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [9:0]       hpos_reg, hpos_next;
  logic [9:0]       vpos_reg, vpos_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;
  logic             display_on_reg, display_on_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             line_start_reg, line_start_next;
  logic             frame_start_reg, frame_start_next;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  // Decoded from registers only, so it is valid the cycle after reset.
  assign tick   = en && (div_cnt_reg == DIV_LAST);
  assign h_wrap = tick && (hpos_reg == H_LAST);
  assign v_wrap = h_wrap && (vpos_reg == V_LAST);

  always_comb begin
    div_cnt_next     = div_cnt_reg;
    hpos_next        = hpos_reg;
    vpos_next        = vpos_reg;
    frame_cnt_next   = frame_cnt_reg;

    if (en) begin
      div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
    end

    if (tick) begin
      hpos_next = h_wrap ? 10'd0 : hpos_reg + 10'd1;
    end

    if (h_wrap) begin
      vpos_next = v_wrap ? 10'd0 : vpos_reg + 10'd1;
    end

    if (v_wrap) begin
      frame_cnt_next = frame_cnt_reg + 8'd1;
    end

    // Decoding the next positions keeps sync/blank aligned with hpos/vpos.
    display_on_next  = (hpos_next < H_ACT_END) && (vpos_next < V_ACT_END);
    hsync_next       = ((hpos_next >= HS_START) && (hpos_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_next       = ((vpos_next >= VS_START) && (vpos_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
    line_start_next  = h_wrap;
    frame_start_next = v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg     <= '0;
      hpos_reg        <= 10'd0;
      vpos_reg        <= 10'd0;
      frame_cnt_reg   <= 8'd0;
      display_on_reg  <= 1'b1;
      hsync_reg       <= ~SYNC_POL;
      vsync_reg       <= ~SYNC_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      hpos_reg        <= hpos_next;
      vpos_reg        <= vpos_next;
      frame_cnt_reg   <= frame_cnt_next;
      display_on_reg  <= display_on_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign pix_tick    = tick;
  assign hpos        = hpos_reg;
  assign vpos        = vpos_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign display_on  = display_on_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (divide-by-1 active-low, divide-by-4
// active-high) on a shrunken raster, checked every cycle against a tick-count model.
module tb_vga_sync_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FT = HT * VT;             // 150 pixels per frame

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [1:0]       pt, dn, hs, vs, ls, fs;
  logic [1:0][9:0]  hp, vp;
  logic [1:0][7:0]  fc;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CLK_DIV(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_tick(pt[0]), .hpos(hp[0]), .vpos(vp[0]),
    .display_on(dn[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .frame_cnt(fc[0])
  );

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .CLK_DIV(4)
  ) dut4 (
    .clk(clk), .rst(rst), .en(en), .pix_tick(pt[1]), .hpos(hp[1]), .vpos(vp[1]),
    .display_on(dn[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .frame_cnt(fc[1])
  );

  int checks   = 0;
  int failures = 0;

  // Model state: enabled clocks and pixel ticks since the last reset.
  int ecnt[2];
  int ticks[2];
  bit mls[2];
  bit mfs[2];

  function automatic int div_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit pol_of(int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ecnt[i] = 0; ticks[i] = 0; mls[i] = 0; mfs[i] = 0;
      end else if (en) begin
        bit t;
        t = (ecnt[i] % div_of(i)) == div_of(i) - 1;
        ecnt[i]++;
        if (t) begin
          ticks[i]++;
          mls[i] = (ticks[i] % HT) == 0;
          mfs[i] = (ticks[i] % FT) == 0;
        end else begin
          mls[i] = 0; mfs[i] = 0;
        end
      end else begin
        mls[i] = 0; mfs[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int h, v, f;
      bit sh, sv;
      h  = ticks[i] % HT;
      v  = (ticks[i] / HT) % VT;
      f  = (ticks[i] / FT) % 256;
      sh = (h >= HA + HF && h < HA + HF + HS) ? pol_of(i) : !pol_of(i);
      sv = (v >= VA + VF && v < VA + VF + VS) ? pol_of(i) : !pol_of(i);
      chk($sformatf("d%0d.pix_tick", i), 32'(pt[i]), 32'(en && (ecnt[i] % div_of(i) == div_of(i) - 1)));
      chk($sformatf("d%0d.hpos", i), 32'(hp[i]), h);
      chk($sformatf("d%0d.vpos", i), 32'(vp[i]), v);
      chk($sformatf("d%0d.frame_cnt", i), 32'(fc[i]), f);
      chk($sformatf("d%0d.display_on", i), 32'(dn[i]), 32'(h < HA && v < VA));
      chk($sformatf("d%0d.hsync", i), 32'(hs[i]), 32'(sh));
      chk($sformatf("d%0d.vsync", i), 32'(vs[i]), 32'(sv));
      chk($sformatf("d%0d.line_start", i), 32'(ls[i]), 32'(mls[i]));
      chk($sformatf("d%0d.frame_start", i), 32'(fs[i]), 32'(mfs[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    bit rst;
    bit en;
    int n;
    int hpos;
    int vpos;
    int fc;
    bit hsync;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt_a, cnt_b, cnt_c;

    // Expectations for the divide-by-1 instance after each segment.
    tbl[0] = '{1, 1,   2,  0, 0, 0, 1};  // reset
    tbl[1] = '{0, 1,  15,  0, 1, 0, 1};  // one full line
    tbl[2] = '{0, 1,  10, 10, 1, 0, 0};  // first hsync pixel
    tbl[3] = '{0, 0,   5, 10, 1, 0, 0};  // frozen
    tbl[4] = '{0, 1,   1, 11, 1, 0, 0};
    tbl[5] = '{0, 1,   2, 13, 1, 0, 1};  // first pixel past hsync
    tbl[6] = '{0, 1, 122,  0, 0, 1, 1};  // frame wrap
    tbl[7] = '{1, 1,   1,  0, 0, 0, 1};  // mid-frame reset

    for (int k = 0; k < 8; k++) begin
      rst = tbl[k].rst;
      en  = tbl[k].en;
      repeat (tbl[k].n) step();
      chk($sformatf("tbl%0d.hpos", k), 32'(hp[0]), tbl[k].hpos);
      chk($sformatf("tbl%0d.vpos", k), 32'(vp[0]), tbl[k].vpos);
      chk($sformatf("tbl%0d.frame_cnt", k), 32'(fc[0]), tbl[k].fc);
      chk($sformatf("tbl%0d.hsync", k), 32'(hs[0]), 32'(tbl[k].hsync));
    end

    // One line from reset: hsync width, single line_start, divided tick rate.
    rst = 1; en = 1; step();
    rst = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < HT; k++) begin
      step();
      if (hs[0] == 1'b0) cnt_a++;
      if (ls[0]) cnt_b++;
    end
    chk("line.hsync_clks", cnt_a, HS);
    chk("line.line_start_cnt", cnt_b, 1);
    chk("line.vpos", 32'(vp[0]), 1);
    rst = 1; step();
    rst = 0;
    for (int k = 0; k < 4 * HT; k++) begin
      step();
      if (pt[1]) cnt_c++;
    end
    chk("div4.tick_cnt", cnt_c, HT);
    chk("div4.vpos", 32'(vp[1]), 1);

    // Freeze mid-hsync and resume on the next pixel.
    for (int k = 0; k < 2 * HT && hp[0] != 10'd11; k++) step();
    chk("freeze.reach", 32'(hp[0]), 11);
    en = 0;
    repeat (50) step();
    chk("freeze.hold", 32'(hp[0]), 11);
    en = 1;
    step();
    chk("freeze.resume", 32'(hp[0]), 12);

    // Randomized enable gaps and occasional resets.
    for (int k = 0; k < 20000; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    // 256 frames from reset: frame counter returns to zero.
    rst = 1; en = 1; step();
    rst = 0;
    cnt_a = 0;
    for (int k = 0; k < 256 * FT; k++) begin
      step();
      if (fs[0]) cnt_a++;
    end
    chk("wrap.frame_start_cnt", cnt_a, 256);
    chk("wrap.frame_cnt", 32'(fc[0]), 0);
    chk("wrap.div4_frame_cnt", 32'(fc[1]), 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
